// File: rtl/hub75_scan_driver.sv
// hub75_scan_driver: read-side scan engine for a 64x64 HUB75 panel (1/32 scan).
// Ports: clk, reset_n (async, active low), enable; col_addr/row_addr out to the
// pixel store, R1..B2 in (one-cycle read latency); panel pins p_r1..p_b2, p_clk,
// p_lat, p_oe_n, p_addr; shifting (read address busy), frame_start (row 0 pulse).
module hub75_scan_driver #(
    parameter int COLS         = 64,
    parameter int ROWS         = 32,
    parameter int ON_CYCLES    = 256,
    parameter int BLANK_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    output logic [5:0] col_addr,
    output logic [4:0] row_addr,
    input  logic       R1,
    input  logic       G1,
    input  logic       B1,
    input  logic       R2,
    input  logic       G2,
    input  logic       B2,
    output logic       p_r1,
    output logic       p_g1,
    output logic       p_b1,
    output logic       p_r2,
    output logic       p_g2,
    output logic       p_b2,
    output logic       p_clk,
    output logic       p_lat,
    output logic       p_oe_n,
    output logic [4:0] p_addr,
    output logic       shifting,
    output logic       frame_start
);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        LATCH,
        DISPLAY,
        BLANK
    } state_t;

    localparam logic [15:0] K_SHIFT_LAST = 16'(2 * COLS + 1);
    localparam logic [15:0] K_DATA_END   = 16'(2 * COLS);
    localparam logic [15:0] K_ON_LAST    = 16'(ON_CYCLES - 1);
    localparam logic [15:0] K_BLANK_LAST = 16'(BLANK_CYCLES - 1);
    localparam logic [4:0]  R_LAST       = 5'(ROWS - 1);
    localparam logic [14:0] COL_LAST     = 15'(COLS - 1);

    state_t      state, state_n;
    logic [15:0] k, k_n;
    logic [4:0]  r, r_n;
    logic [14:0] half;

    always_comb begin
        state_n = state;
        k_n     = k;
        r_n     = r;
        unique case (state)
            IDLE: begin
                r_n = 5'd0;
                if (enable) begin
                    state_n = SHIFT;
                    k_n     = 16'd0;
                end
            end
            SHIFT: begin
                if (k == K_SHIFT_LAST) begin
                    state_n = LATCH;
                    k_n     = 16'd0;
                end else begin
                    k_n = k + 16'd1;
                end
            end
            LATCH: begin
                state_n = DISPLAY;
                k_n     = 16'd0;
            end
            DISPLAY: begin
                if (k == K_ON_LAST) begin
                    state_n = BLANK;
                    k_n     = 16'd0;
                end else begin
                    k_n = k + 16'd1;
                end
            end
            BLANK: begin
                if (k == K_BLANK_LAST) begin
                    k_n = 16'd0;
                    if (enable) begin
                        state_n = SHIFT;
                        r_n     = (r == R_LAST) ? 5'd0 : r + 5'd1;
                    end else begin
                        state_n = IDLE;
                        r_n     = 5'd0;
                    end
                end else begin
                    k_n = k + 16'd1;
                end
            end
            default: begin
                state_n = IDLE;
                k_n     = 16'd0;
                r_n     = 5'd0;
            end
        endcase
    end

    // Read address: two cycles per column, last column held through the
    // two trailing shift cycles; row address prefetches outside SHIFT.
    always_comb begin
        half     = k[15:1];
        col_addr = 6'd0;
        row_addr = r;
        if (state == SHIFT) begin
            col_addr = (half >= COL_LAST) ? COL_LAST[5:0] : half[5:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            k     <= 16'd0;
            r     <= 5'd0;
        end else begin
            state <= state_n;
            k     <= k_n;
            r     <= r_n;
        end
    end

    // Panel controls are registered from the next-state decode so each pin
    // comes straight off a flop yet lines up with the current state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_clk       <= 1'b0;
            p_lat       <= 1'b0;
            p_oe_n      <= 1'b1;
            shifting    <= 1'b0;
            frame_start <= 1'b0;
            p_addr      <= 5'd0;
        end else begin
            p_clk       <= (state_n == SHIFT) && (k_n >= 16'd2) && k_n[0];
            p_lat       <= (state_n == LATCH);
            p_oe_n      <= (state_n != DISPLAY);
            shifting    <= (state_n == SHIFT);
            frame_start <= (state_n == SHIFT) && (k_n == 16'd0) &&
                           (r_n == 5'd0);
            if (state == LATCH) begin
                p_addr <= r;
            end
        end
    end

    // Read data for column c arrives in cycle 2c+1; capture it at the end
    // of that cycle so it is stable across the following low/high p_clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {p_r1, p_g1, p_b1, p_r2, p_g2, p_b2} <= 6'd0;
        end else if ((state == SHIFT) && k[0] && (k < K_DATA_END)) begin
            {p_r1, p_g1, p_b1, p_r2, p_g2, p_b2} <= {R1, G1, B1, R2, G2, B2};
        end
    end

endmodule

// File: tb/tb_hub75_scan_driver.sv
// tb_hub75_scan_driver: directed vector table plus hand-written sequences for
// row/frame timing, enable drop and asynchronous reset of hub75_scan_driver.
module tb_hub75_scan_driver;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [5:0] col_addr;
    logic [4:0] row_addr;
    logic       R1 = 1'b0, G1 = 1'b0, B1 = 1'b0;
    logic       R2 = 1'b0, G2 = 1'b0, B2 = 1'b0;
    logic       p_r1, p_g1, p_b1, p_r2, p_g2, p_b2;
    logic       p_clk, p_lat, p_oe_n;
    logic [4:0] p_addr;
    logic       shifting, frame_start;

    hub75_scan_driver dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .col_addr   (col_addr),
        .row_addr   (row_addr),
        .R1         (R1),
        .G1         (G1),
        .B1         (B1),
        .R2         (R2),
        .G2         (G2),
        .B2         (B2),
        .p_r1       (p_r1),
        .p_g1       (p_g1),
        .p_b1       (p_b1),
        .p_r2       (p_r2),
        .p_g2       (p_g2),
        .p_b2       (p_b2),
        .p_clk      (p_clk),
        .p_lat      (p_lat),
        .p_oe_n     (p_oe_n),
        .p_addr     (p_addr),
        .shifting   (shifting),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Pixel store model: top half = col[2:0], bottom half = ~col[2:0].
    always @(posedge clk) begin
        {R1, G1, B1} <= col_addr[2:0];
        {R2, G2, B2} <= ~col_addr[2:0];
    end

    typedef struct {
        int         t;
        logic       pclk;
        logic       lat;
        logic       oe_n;
        logic       shf;
        logic       fs;
        logic [5:0] col;
        logic [4:0] row;
        logic [4:0] paddr;
        logic       chk_pix;
        logic [5:0] pix;
        string      name;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = -1;
    bit mon_en = 0;

    logic       prev_clk;
    logic       prev_oe;
    int         rise_cnt, shf_cnt, oe_cnt;
    int         lat_t, fs_t, lat_cnt, fs_cnt;
    int         exp_paddr;
    bit         paddr_pending;
    logic [5:0] pins;
    logic [2:0] c3;

    assign pins = {p_r1, p_g1, p_b1, p_r2, p_g2, p_b2};

    function automatic vec_t mk(int t, logic pclk, logic lat, logic oe_n,
                                logic shf, logic fs, logic [5:0] col,
                                logic [4:0] row, logic [4:0] paddr,
                                logic chk_pix, logic [5:0] pix, string name);
        vec_t v;
        v.t = t; v.pclk = pclk; v.lat = lat; v.oe_n = oe_n;
        v.shf = shf; v.fs = fs; v.col = col; v.row = row;
        v.paddr = paddr; v.chk_pix = chk_pix; v.pix = pix; v.name = name;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic monitor();
        if (p_clk && !prev_clk) begin
            c3 = rise_cnt[2:0];
            check("pix_at_rise", {26'd0, pins}, {26'd0, c3, ~c3});
            rise_cnt++;
        end
        if (shifting) shf_cnt++;
        if (!p_oe_n) oe_cnt++;
        if (p_oe_n && !prev_oe) begin
            check("oe_low_len", oe_cnt, 256);
            oe_cnt = 0;
        end
        if (paddr_pending) begin
            check("paddr_step", {27'd0, p_addr}, exp_paddr);
            exp_paddr = (exp_paddr + 1) % 32;
            paddr_pending = 0;
        end
        if (p_lat) begin
            check("lat_while_oe", {31'd0, p_oe_n}, 1);
            check("rises_per_row", rise_cnt, 64);
            check("shift_len", shf_cnt, 130);
            if (lat_t >= 0) check("lat_period", cyc - lat_t, 391);
            rise_cnt = 0;
            shf_cnt = 0;
            lat_t = cyc;
            lat_cnt++;
            paddr_pending = 1;
        end
        if (frame_start) begin
            if (fs_t >= 0) check("frame_period", cyc - fs_t, 12512);
            fs_t = cyc;
            fs_cnt++;
        end
        prev_clk = p_clk;
        prev_oe = p_oe_n;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (mon_en) monitor();
    endtask

    task automatic restart();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cyc = -1;
    endtask

    initial begin
        int base;
        vecs[0]  = mk(0,   0, 0, 1, 1, 1, 6'd0,  5'd0, 5'd0, 1, 6'b000000, "k0");
        vecs[1]  = mk(1,   0, 0, 1, 1, 0, 6'd0,  5'd0, 5'd0, 0, 6'b000000, "k1");
        vecs[2]  = mk(2,   0, 0, 1, 1, 0, 6'd1,  5'd0, 5'd0, 1, 6'b000111, "k2");
        vecs[3]  = mk(3,   1, 0, 1, 1, 0, 6'd1,  5'd0, 5'd0, 1, 6'b000111, "k3");
        vecs[4]  = mk(4,   0, 0, 1, 1, 0, 6'd2,  5'd0, 5'd0, 1, 6'b001110, "k4");
        vecs[5]  = mk(5,   1, 0, 1, 1, 0, 6'd2,  5'd0, 5'd0, 1, 6'b001110, "k5");
        vecs[6]  = mk(127, 1, 0, 1, 1, 0, 6'd63, 5'd0, 5'd0, 1, 6'b110001, "k127");
        vecs[7]  = mk(128, 0, 0, 1, 1, 0, 6'd63, 5'd0, 5'd0, 1, 6'b111000, "k128");
        vecs[8]  = mk(129, 1, 0, 1, 1, 0, 6'd63, 5'd0, 5'd0, 1, 6'b111000, "k129");
        vecs[9]  = mk(130, 0, 1, 1, 0, 0, 6'd0,  5'd0, 5'd0, 1, 6'b111000, "latch0");
        vecs[10] = mk(131, 0, 0, 0, 0, 0, 6'd0,  5'd0, 5'd0, 0, 6'b000000, "disp0_first");
        vecs[11] = mk(386, 0, 0, 0, 0, 0, 6'd0,  5'd0, 5'd0, 0, 6'b000000, "disp0_last");
        vecs[12] = mk(387, 0, 0, 1, 0, 0, 6'd0,  5'd0, 5'd0, 0, 6'b000000, "blank0_first");
        vecs[13] = mk(390, 0, 0, 1, 0, 0, 6'd0,  5'd0, 5'd0, 0, 6'b000000, "blank0_last");
        vecs[14] = mk(391, 0, 0, 1, 1, 0, 6'd0,  5'd1, 5'd0, 0, 6'b000000, "shift1_k0");
        vecs[15] = mk(520, 1, 0, 1, 1, 0, 6'd63, 5'd1, 5'd0, 0, 6'b000000, "shift1_last");
        vecs[16] = mk(521, 0, 1, 1, 0, 0, 6'd0,  5'd1, 5'd0, 0, 6'b000000, "latch1");
        vecs[17] = mk(522, 0, 0, 0, 0, 0, 6'd0,  5'd1, 5'd1, 0, 6'b000000, "disp1");

        reset_n = 1'b0;
        enable = 1'b1;
        repeat (3) tick();
        check("reset_outputs",
              {p_r1, p_g1, p_b1, p_r2, p_g2, p_b2, p_clk, p_lat, p_oe_n,
               shifting, frame_start, col_addr, row_addr, p_addr},
              {6'd0, 3'b001, 2'b00, 6'd0, 5'd0, 5'd0});

        prev_clk = 1'b0; prev_oe = 1'b1;
        rise_cnt = 0; shf_cnt = 0; oe_cnt = 0;
        lat_t = -1; fs_t = -1; lat_cnt = 0; fs_cnt = 0;
        exp_paddr = 0; paddr_pending = 0;
        reset_n = 1'b1;
        cyc = -1;
        mon_en = 1;

        for (int i = 0; i < NV; i++) begin
            while (cyc < vecs[i].t) tick();
            check(vecs[i].name,
                  {p_clk, p_lat, p_oe_n, shifting, frame_start,
                   col_addr, row_addr, p_addr},
                  {vecs[i].pclk, vecs[i].lat, vecs[i].oe_n, vecs[i].shf,
                   vecs[i].fs, vecs[i].col, vecs[i].row, vecs[i].paddr});
            if (vecs[i].chk_pix) begin
                check({vecs[i].name, "_pix"}, {26'd0, pins},
                      {26'd0, vecs[i].pix});
            end
        end
        while (cyc < 25423) tick();
        check("lat_count", lat_cnt, 65);
        check("frame_count", fs_cnt, 3);
        mon_en = 0;

        restart();
        while (cyc < 2096) tick();
        check("row5_display", {p_oe_n, shifting, row_addr, p_addr},
              {1'b0, 1'b0, 5'd5, 5'd5});
        enable = 1'b0;
        while (cyc < 2345) tick();
        check("row5_blank_last", {p_oe_n, shifting, row_addr},
              {1'b1, 1'b0, 5'd5});
        tick();
        check("idle_after_drop",
              {p_oe_n, shifting, p_lat, frame_start, row_addr},
              {1'b1, 1'b0, 1'b0, 1'b0, 5'd0});
        repeat (5) tick();
        check("idle_holds", {p_oe_n, shifting}, 2'b10);
        enable = 1'b1;
        tick();
        check("reenable_restart", {shifting, frame_start, row_addr},
              {1'b1, 1'b1, 5'd0});

        base = cyc;
        while (cyc < base + 41) tick();
        check("k41_pclk_high", {31'd0, p_clk}, 1);
        reset_n = 1'b0;
        #1;
        check("midshift_reset",
              {p_clk, p_oe_n, shifting, p_lat, frame_start}, 5'b01000);
        tick();
        reset_n = 1'b1;
        tick();
        check("restart_row0", {shifting, frame_start, row_addr, col_addr},
              {1'b1, 1'b1, 5'd0, 6'd0});
        base = cyc;
        while (cyc < base + 140) tick();
        check("display_before_reset", {p_oe_n, p_addr}, {1'b0, 5'd0});
        reset_n = 1'b0;
        #1;
        check("display_reset_blank", {p_oe_n, p_lat}, 2'b10);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
